// File: rtl/sample_packer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sample_packer_pkg
//  Description : Shared types and widths for the sample packer: packer state
//                encoding, packed output word width and per-sample half width.
//  Revision    : 1.0 - initial release
// ============================================================================
package sample_packer_pkg;

    localparam int OUT_WIDTH  = 32;
    localparam int HALF_WIDTH = 16;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,   // capture disabled
        S_LO   = 2'd1,   // waiting for the first sample of a pair
        S_HI   = 2'd2    // waiting for the second sample of a pair
    } state_t;

endpackage : sample_packer_pkg
`default_nettype wire

// File: rtl/axis_out_reg.sv
`default_nettype none
// ============================================================================
//  Module      : axis_out_reg
//  Description : Single-entry AXI-Stream output register. A load places a word
//                and its last flag into the register and raises valid; the
//                word is held unchanged until the sink accepts it.
//  Ports       : clk, rst_n     - clock, synchronous active-low reset
//                load           - capture load_data/load_last this cycle
//                load_data/last - word and last flag to capture
//                tready         - sink ready
//                tdata/tvalid/tlast - registered AXI-Stream outputs
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_out_reg
    import sample_packer_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [OUT_WIDTH-1:0] load_data,
    input  logic                 load_last,
    input  logic                 tready,
    output logic [OUT_WIDTH-1:0] tdata,
    output logic                 tvalid,
    output logic                 tlast
);

    // The caller only asserts load when the register is empty or being
    // drained this cycle, so a load always wins over the drain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tdata  <= '0;
            tvalid <= 1'b0;
            tlast  <= 1'b0;
        end else if (load) begin
            tdata  <= load_data;
            tlast  <= load_last;
            tvalid <= 1'b1;
        end else if (tready) begin
            tvalid <= 1'b0;
        end
    end

endmodule : axis_out_reg
`default_nettype wire

// File: rtl/sample_packer.sv
`default_nettype none
// ============================================================================
//  Module      : sample_packer
//  Description : Packs pairs of decimated samples into 32-bit AXI-Stream words
//                {fmt(second), fmt(first)}, frames them into packets of
//                pkt_len_reg words with tlast, and counts samples dropped under
//                back-pressure.
//  Ports       : clk, rst_n            - clock, synchronous active-low reset
//                enable                - capture enable
//                in_data_valid/ready/in_data - sample input handshake
//                pkt_len_reg           - words per packet (0 behaves as 1)
//                m_axis_tdata/tvalid/tready/tlast - packed word stream
//                drop_cnt              - saturating dropped-sample count
//  Revision    : 1.0 - initial release
// ============================================================================
module sample_packer
    import sample_packer_pkg::*;
#(
    parameter int DATA_IN_WIDTH  = 12,
    parameter int DATA_REG_WIDTH = 32,
    parameter int OFFSET_BIN     = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic                      in_data_valid,
    output logic                      in_data_ready,
    input  logic [DATA_IN_WIDTH-1:0]  in_data,
    input  logic [DATA_REG_WIDTH-1:0] pkt_len_reg,
    output logic [OUT_WIDTH-1:0]      m_axis_tdata,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic                      m_axis_tlast,
    output logic [DATA_REG_WIDTH-1:0] drop_cnt
);

    localparam logic [DATA_REG_WIDTH-1:0] ONE = {{(DATA_REG_WIDTH-1){1'b0}}, 1'b1};

    state_t                    state;
    state_t                    state_next;
    logic [HALF_WIDTH-1:0]     lo_half;
    logic [HALF_WIDTH-1:0]     fmt_in;
    logic [DATA_IN_WIDTH-1:0]  conv;
    logic [DATA_REG_WIDTH-1:0] word_cnt;
    logic [DATA_REG_WIDTH-1:0] len_latched;
    logic [DATA_REG_WIDTH-1:0] len_eff;
    logic                      accept;
    logic                      load;
    logic                      last_word;
    logic                      drop;

    // ---------------- sample formatting ----------------
    always_comb begin
        conv = in_data;
        if (OFFSET_BIN == 1) begin
            conv[DATA_IN_WIDTH-1] = ~in_data[DATA_IN_WIDTH-1];
        end
    end

    generate
        if (DATA_IN_WIDTH < HALF_WIDTH) begin : g_sext
            assign fmt_in = {{(HALF_WIDTH-DATA_IN_WIDTH){conv[DATA_IN_WIDTH-1]}}, conv};
        end else begin : g_full
            assign fmt_in = conv[HALF_WIDTH-1:0];
        end
    endgenerate

    // ---------------- handshake ----------------
    // Idle is excluded so a sample arriving in the cycle enable rises is
    // neither captured nor counted as a drop.
    assign in_data_ready = enable && (state != S_IDLE) && (!m_axis_tvalid || m_axis_tready);
    assign accept        = in_data_valid && in_data_ready && enable;
    assign load          = accept && (state == S_HI);
    assign drop          = in_data_valid && enable && !in_data_ready && (state != S_IDLE);

    // ---------------- packet framing ----------------
    // The first word of a packet uses the live length register (which is
    // latched at that load); later words use the latched copy so mid-packet
    // writes only affect the next packet.
    always_comb begin
        if (word_cnt == '0) begin
            len_eff = (pkt_len_reg == '0) ? ONE : pkt_len_reg;
        end else begin
            len_eff = len_latched;
        end
    end

    assign last_word = (word_cnt == (len_eff - ONE));

    // ---------------- FSM ----------------
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (enable) state_next = S_LO;
            S_LO:    if (!enable) state_next = S_IDLE;
                     else if (accept) state_next = S_HI;
            S_HI:    if (!enable) state_next = S_IDLE;
                     else if (accept) state_next = S_LO;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            lo_half     <= '0;
            word_cnt    <= '0;
            len_latched <= '0;
            drop_cnt    <= '0;
        end else begin
            state <= state_next;

            if (!enable) begin
                lo_half  <= '0;
                word_cnt <= '0;
            end else begin
                if (accept && (state == S_LO)) begin
                    lo_half <= fmt_in;
                end
                if (load) begin
                    if (word_cnt == '0) begin
                        len_latched <= len_eff;
                    end
                    word_cnt <= last_word ? '0 : (word_cnt + ONE);
                end
            end

            if (drop && (drop_cnt != {DATA_REG_WIDTH{1'b1}})) begin
                drop_cnt <= drop_cnt + ONE;
            end
        end
    end

    // ---------------- output register ----------------
    axis_out_reg u_out (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .load_data ({fmt_in, lo_half}),
        .load_last (last_word),
        .tready    (m_axis_tready),
        .tdata     (m_axis_tdata),
        .tvalid    (m_axis_tvalid),
        .tlast     (m_axis_tlast)
    );

endmodule : sample_packer
`default_nettype wire
